// File: rtl/multi_task_score_sched_if.sv
// multi_task_score_sched_if: config, control and result bundle of the score scheduler
interface multi_task_score_sched_if #(
  parameter int NUM_TASKS      = 8,
  parameter int SCORE_BITWIDTH = 32,
  parameter int TIME_WIDTH     = 32
);
  localparam int IW = $clog2(NUM_TASKS);
  logic                      cfg_wr_en;
  logic                      cfg_rdy;
  logic [IW-1:0]             cfg_idx;
  logic                      cfg_valid;
  logic [SCORE_BITWIDTH-1:0] cfg_lr;
  logic [SCORE_BITWIDTH-1:0] cfg_lat;
  logic [SCORE_BITWIDTH-1:0] cfg_norm_iso;
  logic [TIME_WIDTH-1:0]     cfg_ddl;
  logic [TIME_WIDTH-1:0]     cfg_exe_clk;
  logic [TIME_WIDTH-1:0]     sys_clk;
  logic                      start;
  logic                      busy;
  logic                      res_vld;
  logic                      res_rdy;
  logic [IW-1:0]             res_idx;
  logic [SCORE_BITWIDTH-1:0] res_score;
  logic                      res_none;
  modport master (
    output cfg_wr_en, cfg_idx, cfg_valid, cfg_lr, cfg_lat, cfg_norm_iso, cfg_ddl, cfg_exe_clk,
           sys_clk, start, res_rdy,
    input  cfg_rdy, busy, res_vld, res_idx, res_score, res_none
  );
  modport slave (
    input  cfg_wr_en, cfg_idx, cfg_valid, cfg_lr, cfg_lat, cfg_norm_iso, cfg_ddl, cfg_exe_clk,
           sys_clk, start, res_rdy,
    output cfg_rdy, busy, res_vld, res_idx, res_score, res_none
  );
endinterface

// File: rtl/multi_task_score_sched.sv
// multi_task_score_sched: picks the minimum-score valid task through a 3-stage fixed-point pipeline
module multi_task_score_sched #(
  parameter int NUM_TASKS      = 8,
  parameter int SCORE_BITWIDTH = 32,
  parameter int FRAC_BITS      = 16,
  parameter int TIME_WIDTH     = 32,
  parameter int BETA_Q         = 655
) (
  input logic                    clk,
  input logic                    reset_n,
  multi_task_score_sched_if.slave bus
);
  localparam int SW = SCORE_BITWIDTH;
  localparam int TW = TIME_WIDTH;
  localparam int F  = FRAC_BITS;
  localparam int IW = $clog2(NUM_TASKS);
  localparam int WW = 2 * SW + TW + F;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t          state, state_n;
  logic [IW:0]     cnt;
  logic [TW-1:0]   sys_q;
  logic            t_vld [NUM_TASKS];
  logic [SW-1:0]   t_lr  [NUM_TASKS];
  logic [SW-1:0]   t_lat [NUM_TASKS];
  logic [SW-1:0]   t_iso [NUM_TASKS];
  logic [TW-1:0]   t_ddl [NUM_TASKS];
  logic [TW-1:0]   t_exe [NUM_TASKS];
  logic            v1, v2, m_found, res_none;
  logic [IW-1:0]   ti, i1, i2, m_idx, res_idx;
  logic [2*SW-1:0] prod1;
  logic [TW-1:0]   slack1, wait1;
  logic [SW-1:0]   iso1, base2, cost2, m_score, res_score;
  logic [SW-1:0]   base, pen, cost, bterm, score;
  logic [TW:0]     sd, wd;
  logic            cfg_rdy, keep;
  function automatic logic [SW-1:0] sat(input logic [WW-1:0] x);
    return |x[WW-1:SW] ? '1 : x[SW-1:0];
  endfunction
  assign ti      = cnt[IW-1:0];
  assign cfg_rdy = (state == IDLE) || (state == DONE);
  assign bus.cfg_rdy   = cfg_rdy;
  assign bus.busy      = (state == ISSUE) || (state == DRAIN);
  assign bus.res_vld   = state == DONE;
  assign bus.res_idx   = res_idx;
  assign bus.res_score = res_score;
  assign bus.res_none  = res_none;
  // state register plus a shared cycle counter that restarts on every state change
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= (state_n != state) ? '0 : cnt + 1'b1;
    end
  end
  // next state: one issue slot per entry, then three cycles for the pipeline to empty
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  state_n = bus.start ? ISSUE : IDLE;
      ISSUE: state_n = (cnt == (IW+1)'(NUM_TASKS - 1)) ? DRAIN : ISSUE;
      DRAIN: state_n = (cnt == (IW+1)'(2)) ? DONE : DRAIN;
      DONE:  state_n = bus.res_rdy ? IDLE : DONE;
    endcase
  end
  // stage arithmetic: clamped time deltas, then saturating base/cost, then score
  always_comb begin
    sd    = {1'b0, t_ddl[ti]} - {1'b0, sys_q};
    wd    = {1'b0, sys_q} - {1'b0, t_exe[ti]};
    base  = sat(WW'(prod1 >> F));
    pen   = sat(WW'(wait1) * WW'(iso1));
    cost  = sat((WW'(slack1) << F) + WW'(pen));
    bterm = sat((WW'(BETA_Q) * WW'(cost2)) >> F);
    score = sat(WW'(base2) + WW'(bterm));
    keep  = v2 && (!m_found || score < m_score);
  end
  // task table, pipeline registers, running minimum and the held result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_TASKS; k++) begin
        t_vld[k] <= 1'b0;
        t_lr[k]  <= '0;
        t_lat[k] <= '0;
        t_iso[k] <= '0;
        t_ddl[k] <= '0;
        t_exe[k] <= '0;
      end
      sys_q     <= '0;
      v1        <= 1'b0;
      i1        <= '0;
      prod1     <= '0;
      slack1    <= '0;
      wait1     <= '0;
      iso1      <= '0;
      v2        <= 1'b0;
      i2        <= '0;
      base2     <= '0;
      cost2     <= '0;
      m_found   <= 1'b0;
      m_idx     <= '0;
      m_score   <= '1;
      res_idx   <= '0;
      res_score <= '0;
      res_none  <= 1'b0;
    end else begin
      if (bus.cfg_wr_en && cfg_rdy) begin
        t_vld[bus.cfg_idx] <= bus.cfg_valid;
        t_lr[bus.cfg_idx]  <= bus.cfg_lr;
        t_lat[bus.cfg_idx] <= bus.cfg_lat;
        t_iso[bus.cfg_idx] <= bus.cfg_norm_iso;
        t_ddl[bus.cfg_idx] <= bus.cfg_ddl;
        t_exe[bus.cfg_idx] <= bus.cfg_exe_clk;
      end
      v1     <= (state == ISSUE) && t_vld[ti];
      i1     <= ti;
      prod1  <= (2*SW)'(t_lr[ti]) * (2*SW)'(t_lat[ti]);
      slack1 <= sd[TW] ? '0 : sd[TW-1:0];
      wait1  <= wd[TW] ? '0 : wd[TW-1:0];
      iso1   <= t_iso[ti];
      v2     <= v1;
      i2     <= i1;
      base2  <= base;
      cost2  <= cost;
      if (state == IDLE && bus.start) begin
        sys_q   <= bus.sys_clk;
        m_found <= 1'b0;
        m_idx   <= '0;
        m_score <= '1;
      end else if (keep) begin
        m_found <= 1'b1;
        m_idx   <= i2;
        m_score <= score;
      end
      if (state == DRAIN && state_n == DONE) begin
        res_idx   <= m_idx;
        res_score <= m_score;
        res_none  <= !m_found;
      end
    end
  end
endmodule

// File: tb/tb_multi_task_score_sched.sv
// tb_multi_task_score_sched: directed checks of scoring, ties, saturation, backpressure and reset
module tb_multi_task_score_sched;
  localparam int N = 4;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int checks = 0;
  int failures = 0;
  multi_task_score_sched_if #(.NUM_TASKS(N), .SCORE_BITWIDTH(32), .TIME_WIDTH(32)) bus ();
  multi_task_score_sched #(
    .NUM_TASKS(N), .SCORE_BITWIDTH(32), .FRAC_BITS(16), .TIME_WIDTH(32), .BETA_Q(655)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [1:0] idx, input logic vld, input logic [31:0] lr, lat, iso, ddl, exe);
    bus.cfg_idx = idx; bus.cfg_valid = vld; bus.cfg_lr = lr; bus.cfg_lat = lat;
    bus.cfg_norm_iso = iso; bus.cfg_ddl = ddl; bus.cfg_exe_clk = exe;
    bus.cfg_wr_en = 1'b1;
    step();
    bus.cfg_wr_en = 1'b0;
  endtask
  task automatic run_pass(input bit inject);
    int n;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    n = 1;
    if (inject) bus.cfg_wr_en = 1'b1;
    while (!bus.res_vld && n < 50) begin
      chk("busy_in_pass", bus.busy, 1);
      chk("cfg_rdy_in_pass", bus.cfg_rdy, 0);
      step();
      bus.cfg_wr_en = 1'b0;
      n++;
    end
    chk("latency", n, N + 4);
    chk("busy_done", bus.busy, 0);
    chk("cfg_rdy_done", bus.cfg_rdy, 1);
  endtask
  task automatic accept();
    bus.res_rdy = 1'b1;
    step();
    bus.res_rdy = 1'b0;
    chk("vld_after_accept", bus.res_vld, 0);
    chk("cfg_rdy_after_accept", bus.cfg_rdy, 1);
  endtask
  task automatic chk_res(input logic [1:0] idx, input logic [31:0] score, input logic none);
    chk("res_idx", bus.res_idx, idx);
    chk("res_score", bus.res_score, score);
    chk("res_none", bus.res_none, none);
  endtask
  initial begin
    bus.cfg_wr_en = 0; bus.cfg_idx = 0; bus.cfg_valid = 0; bus.cfg_lr = 0; bus.cfg_lat = 0;
    bus.cfg_norm_iso = 0; bus.cfg_ddl = 0; bus.cfg_exe_clk = 0; bus.sys_clk = 32'd1000;
    bus.start = 0; bus.res_rdy = 0;
    #3 reset_n = 1'b0;
    #1;
    chk("rst_vld", bus.res_vld, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_cfg_rdy", bus.cfg_rdy, 1);
    chk_res(0, 0, 0);
    step();
    reset_n = 1'b1;
    step();
    wr(0, 1, 32'd65536, 32'd655360, 32'd0, 32'd1100, 32'd1000);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step(); step();
    chk("busy_before_abort", bus.busy, 1);
    reset_n = 1'b0;
    #1;
    chk("abort_vld", bus.res_vld, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_cfg_rdy", bus.cfg_rdy, 1);
    step();
    reset_n = 1'b1;
    step();
    run_pass(0);
    chk_res(0, 32'hFFFF_FFFF, 1);
    accept();
    wr(0, 1, 32'd65536, 32'd655360, 32'd0, 32'd1100, 32'd1000);
    wr(1, 1, 32'd32768, 32'd655360, 32'd65536, 32'd900, 32'd990);
    run_pass(0);
    chk_res(1, 32'd334230, 0);
    for (int i = 0; i < 20; i++) begin
      bus.start = (i == 3);
      if (i == 5) begin
        bus.cfg_idx = 2; bus.cfg_valid = 1; bus.cfg_lr = 0; bus.cfg_lat = 0;
        bus.cfg_norm_iso = 0; bus.cfg_ddl = 32'd1000; bus.cfg_exe_clk = 32'd1000;
      end
      bus.cfg_wr_en = (i == 5);
      step();
      chk("bp_vld", bus.res_vld, 1);
      chk("bp_busy", bus.busy, 0);
      chk("bp_idx", bus.res_idx, 1);
      chk("bp_score", bus.res_score, 32'd334230);
    end
    bus.start = 1'b0;
    bus.cfg_wr_en = 1'b0;
    accept();
    run_pass(0);
    chk_res(2, 32'd0, 0);
    accept();
    wr(0, 0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    wr(1, 0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    wr(2, 1, 32'd65536, 32'd655360, 32'd0, 32'd1100, 32'd1000);
    wr(3, 1, 32'd65536, 32'd655360, 32'd0, 32'd1100, 32'd1000);
    run_pass(0);
    chk_res(2, 32'd720860, 0);
    accept();
    bus.sys_clk = 32'd0;
    wr(2, 0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    wr(3, 0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    wr(0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'd0);
    bus.cfg_idx = 1; bus.cfg_valid = 1; bus.cfg_lr = 0; bus.cfg_lat = 0;
    bus.cfg_norm_iso = 0; bus.cfg_ddl = 0; bus.cfg_exe_clk = 0;
    run_pass(1);
    chk_res(0, 32'hFFFF_FFFF, 0);
    accept();
    run_pass(0);
    chk_res(0, 32'hFFFF_FFFF, 0);
    accept();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
